wb_initiator: RTL and testbench

Wishbone classic single-cycle bus master that turns a simple valid/ready request stream into one bus transaction at a time and returns the result on a valid/ready response stream. It is the initiator counterpart of the accelerator's slave-side decode and mux for the sudoku engine at 0x3000_0000 and the UART at 0x3080_0000. It lets on-chip agents, such as a debug bridge or a self-test sequencer, drive that address space without a CPU. A bounded ack timeout guarantees the master never hangs on an unmapped address.

---
 rtl/wb_initiator_pkg.sv | 16 +
 rtl/wb_initiator_if.sv | 36 +++
 rtl/wb_timeout_counter.sv | 29 ++
 rtl/wb_initiator.sv | 118 +++++++++++
 tb/tb_wb_initiator.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone classic single-transaction initiator.
// Bus widths, default ack timeout and the controller state encoding.
package wb_initiator_pkg;

  localparam int unsigned WB_ADR_W        = 32;
  localparam int unsigned WB_DAT_W        = 32;
  localparam int unsigned WB_SEL_W        = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_initiator_if.sv
// Wishbone classic bus signals between the initiator (master) and the addressed slave.
// Signal names keep the master-side _o/_i suffixes used on the bus.
interface wb_initiator_if;

  logic [wb_initiator_pkg::WB_ADR_W-1:0] wb_adr_o;
  logic [wb_initiator_pkg::WB_DAT_W-1:0] wb_dat_o;
  logic [wb_initiator_pkg::WB_SEL_W-1:0] wb_sel_o;
  logic                                  wb_we_o;
  logic                                  wb_cyc_o;
  logic                                  wb_stb_o;
  logic                                  wb_ack_i;
  logic [wb_initiator_pkg::WB_DAT_W-1:0] wb_dat_i;

  modport master (
    output wb_adr_o,
    output wb_dat_o,
    output wb_sel_o,
    output wb_we_o,
    output wb_cyc_o,
    output wb_stb_o,
    input  wb_ack_i,
    input  wb_dat_i
  );

  modport slave (
    input  wb_adr_o,
    input  wb_dat_o,
    input  wb_sel_o,
    input  wb_we_o,
    input  wb_cyc_o,
    input  wb_stb_o,
    output wb_ack_i,
    output wb_dat_i
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// Ack-wait down-to-abort timer: counts strobe cycles without ack and flags the last one.
// expired is true while the count sits at TIMEOUT-1.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT = wb_initiator_pkg::DEFAULT_TIMEOUT
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] count;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count <= 16'd0;
    end else if (clr) begin
      count <= 16'd0;
    end else if (en) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic master: one request in, one bus cycle, one response out.
// A bounded ack wait aborts cycles to unmapped addresses with rsp_err.
//
// state | meaning
// IDLE  | ready for a request, bus idle-clean
// BUS   | cyc/stb asserted, waiting for ack or timeout
// RESP  | response held on rsp_* until rsp_ready
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,

  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WB_ADR_W-1:0] req_adr,
  input  logic [WB_DAT_W-1:0] req_dat,
  input  logic [WB_SEL_W-1:0] req_sel,
  input  logic                req_we,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                rsp_err,

  wb_initiator_if.master      wb,

  output logic [7:0]          timeout_count
);

  wb_state_e state;
  logic      cnt_clr;
  logic      cnt_en;
  logic      expired;

  assign req_ready = (state == IDLE);
  assign cnt_clr   = (state == IDLE) && req_valid;
  assign cnt_en    = (state == BUS) && !wb.wb_ack_i;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .expired  (expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      wb.wb_adr_o   <= '0;
      wb.wb_dat_o   <= '0;
      wb.wb_sel_o   <= '0;
      wb.wb_we_o    <= 1'b0;
      wb.wb_cyc_o   <= 1'b0;
      wb.wb_stb_o   <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_dat       <= '0;
      rsp_err       <= 1'b0;
      timeout_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wb.wb_adr_o <= req_adr;
            wb.wb_dat_o <= req_dat;
            wb.wb_sel_o <= req_sel;
            wb.wb_we_o  <= req_we;
            wb.wb_cyc_o <= 1'b1;
            wb.wb_stb_o <= 1'b1;
            state       <= BUS;
          end
        end

        BUS: begin
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (wb.wb_ack_i || expired) begin
            if (wb.wb_ack_i) begin
              rsp_dat <= wb.wb_we_o ? '0 : wb.wb_dat_i;
              rsp_err <= 1'b0;
            end else begin
              rsp_dat <= '0;
              rsp_err <= 1'b1;
              if (timeout_count != 8'hFF) begin
                timeout_count <= timeout_count + 8'd1;
              end
            end
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
            wb.wb_sel_o <= '0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end

        RESP: begin
          // Late acks land here and are dropped.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: directed scenarios plus randomized traffic against a
// transaction-level model; a second instance with TIMEOUT=1 checks saturation.
module tb_wb_initiator;

  localparam int TA = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A (TIMEOUT=4)
  logic        a_rst, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_adr, a_req_dat, a_rsp_dat;
  logic [3:0]  a_req_sel;
  logic [7:0]  a_tc;
  wb_initiator_if ifa();

  wb_initiator #(.TIMEOUT(TA)) dut_a (
    .wb_clk_i      (clk),
    .wb_rst_i      (a_rst),
    .req_valid     (a_req_valid),
    .req_ready     (a_req_ready),
    .req_adr       (a_req_adr),
    .req_dat       (a_req_dat),
    .req_sel       (a_req_sel),
    .req_we        (a_req_we),
    .rsp_valid     (a_rsp_valid),
    .rsp_ready     (a_rsp_ready),
    .rsp_dat       (a_rsp_dat),
    .rsp_err       (a_rsp_err),
    .wb            (ifa),
    .timeout_count (a_tc)
  );

  // Instance B (TIMEOUT=1)
  logic        b_rst, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_adr, b_req_dat, b_rsp_dat;
  logic [3:0]  b_req_sel;
  logic [7:0]  b_tc;
  wb_initiator_if ifb();

  wb_initiator #(.TIMEOUT(1)) dut_b (
    .wb_clk_i      (clk),
    .wb_rst_i      (b_rst),
    .req_valid     (b_req_valid),
    .req_ready     (b_req_ready),
    .req_adr       (b_req_adr),
    .req_dat       (b_req_dat),
    .req_sel       (b_req_sel),
    .req_we        (b_req_we),
    .rsp_valid     (b_rsp_valid),
    .rsp_ready     (b_rsp_ready),
    .rsp_dat       (b_rsp_dat),
    .rsp_err       (b_rsp_err),
    .wb            (ifb),
    .timeout_count (b_tc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Transaction-level model of instance A: one outstanding transfer, tracked as
  // "on the bus for m_stb cycles" or "response waiting", sampled at each edge.
  logic        a_chk_en = 1'b0;
  logic        m_bus = 1'b0, m_rsp = 1'b0, m_we = 1'b0, m_rerr = 1'b0;
  logic [31:0] m_adr = '0, m_dat = '0, m_rdat = '0;
  logic [3:0]  m_sel = '0;
  int          m_stb = 0;
  int          m_tc  = 0;

  always @(posedge clk) begin
    if (a_rst) begin
      m_bus  <= 1'b0;
      m_rsp  <= 1'b0;
      m_tc   <= 0;
      m_rdat <= '0;
      m_rerr <= 1'b0;
    end else if (m_rsp) begin
      if (a_rsp_ready) m_rsp <= 1'b0;
    end else if (m_bus) begin
      if (ifa.wb_ack_i) begin
        m_bus  <= 1'b0;
        m_rsp  <= 1'b1;
        m_rerr <= 1'b0;
        m_rdat <= m_we ? 32'd0 : ifa.wb_dat_i;
      end else if (m_stb + 1 == TA) begin
        m_bus  <= 1'b0;
        m_rsp  <= 1'b1;
        m_rerr <= 1'b1;
        m_rdat <= 32'd0;
        m_tc   <= (m_tc < 255) ? m_tc + 1 : 255;
      end else begin
        m_stb <= m_stb + 1;
      end
    end else if (a_req_valid) begin
      m_bus <= 1'b1;
      m_stb <= 0;
      m_adr <= a_req_adr;
      m_dat <= a_req_dat;
      m_sel <= a_req_sel;
      m_we  <= a_req_we;
    end
  end

  always @(negedge clk) begin
    if (a_chk_en) begin
      chk("m req_ready", 32'(a_req_ready), 32'(!m_bus && !m_rsp));
      chk("m cyc", 32'(ifa.wb_cyc_o), 32'(m_bus));
      chk("m stb", 32'(ifa.wb_stb_o), 32'(m_bus));
      chk("m adr", ifa.wb_adr_o, m_bus ? m_adr : 32'd0);
      chk("m dat", ifa.wb_dat_o, m_bus ? m_dat : 32'd0);
      chk("m sel", 32'(ifa.wb_sel_o), m_bus ? 32'(m_sel) : 32'd0);
      chk("m we", 32'(ifa.wb_we_o), 32'(m_bus && m_we));
      chk("m rsp_valid", 32'(a_rsp_valid), 32'(m_rsp));
      if (m_rsp) begin
        chk("m rsp_dat", a_rsp_dat, m_rdat);
        chk("m rsp_err", 32'(a_rsp_err), 32'(m_rerr));
      end
      chk("m timeout_count", 32'(a_tc), 32'(m_tc));
    end
  end

  task automatic run_a();
    a_rst = 1'b1; a_req_valid = 1'b0; a_req_adr = '0; a_req_dat = '0; a_req_sel = '0;
    a_req_we = 1'b0; a_rsp_ready = 1'b0; ifa.wb_ack_i = 1'b0; ifa.wb_dat_i = '0;
    tick();
    a_chk_en = 1'b1;
    tick();
    a_rst = 1'b0;
    at_neg();
    chk("reset req_ready", 32'(a_req_ready), 32'd1);
    chk("reset cyc", 32'(ifa.wb_cyc_o), 32'd0);
    chk("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("reset timeout_count", 32'(a_tc), 32'd0);

    // write, ack in cycle 2
    a_req_valid = 1'b1; a_req_adr = 32'h3000_0004; a_req_dat = 32'hDEAD_BEEF;
    a_req_sel = 4'hF; a_req_we = 1'b1; a_rsp_ready = 1'b1;
    tick(); a_req_valid = 1'b0;
    at_neg();
    chk("wr c1 adr", ifa.wb_adr_o, 32'h3000_0004);
    chk("wr c1 dat", ifa.wb_dat_o, 32'hDEAD_BEEF);
    chk("wr c1 we", 32'(ifa.wb_we_o), 32'd1);
    tick(); ifa.wb_ack_i = 1'b1;
    at_neg();
    chk("wr c2 adr", ifa.wb_adr_o, 32'h3000_0004);
    chk("wr c2 dat", ifa.wb_dat_o, 32'hDEAD_BEEF);
    tick(); ifa.wb_ack_i = 1'b0;
    at_neg();
    chk("wr c3 rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("wr c3 rsp_dat", a_rsp_dat, 32'd0);
    chk("wr c3 rsp_err", 32'(a_rsp_err), 32'd0);
    chk("wr c3 adr clean", ifa.wb_adr_o, 32'd0);
    tick();
    at_neg();
    chk("wr c4 req_ready", 32'(a_req_ready), 32'd1);

    // read, ack in cycle 1
    a_req_valid = 1'b1; a_req_adr = 32'h3080_0008; a_req_dat = '0; a_req_we = 1'b0;
    tick(); a_req_valid = 1'b0; ifa.wb_ack_i = 1'b1; ifa.wb_dat_i = 32'h0000_00A5;
    tick(); ifa.wb_ack_i = 1'b0; ifa.wb_dat_i = '0;
    at_neg();
    chk("rd c2 cyc", 32'(ifa.wb_cyc_o), 32'd0);
    chk("rd c2 rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("rd c2 rsp_dat", a_rsp_dat, 32'h0000_00A5);
    chk("rd c2 rsp_err", 32'(a_rsp_err), 32'd0);
    tick();

    // timeout with no ack
    a_req_valid = 1'b1; a_req_adr = 32'h4000_0000;
    tick(); a_req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      at_neg();
      chk("to stb high", 32'(ifa.wb_stb_o), 32'd1);
      tick();
    end
    at_neg();
    chk("to c5 stb", 32'(ifa.wb_stb_o), 32'd0);
    chk("to c5 rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("to c5 rsp_err", 32'(a_rsp_err), 32'd1);
    chk("to c5 rsp_dat", a_rsp_dat, 32'd0);
    chk("to c5 timeout_count", 32'(a_tc), 32'd1);
    tick();

    // ack in cycle 4 coincides with the timeout: ack wins
    a_req_valid = 1'b1; a_req_adr = 32'h3000_0010;
    tick(); a_req_valid = 1'b0;
    tick(); tick(); tick();
    ifa.wb_ack_i = 1'b1; ifa.wb_dat_i = 32'h1234_5678;
    at_neg();
    chk("ack4 stb", 32'(ifa.wb_stb_o), 32'd1);
    tick(); ifa.wb_ack_i = 1'b0; a_rsp_ready = 1'b0;
    at_neg();
    chk("ack4 rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("ack4 rsp_err", 32'(a_rsp_err), 32'd0);
    chk("ack4 rsp_dat", a_rsp_dat, 32'h1234_5678);
    chk("ack4 timeout_count", 32'(a_tc), 32'd1);

    // backpressure for 10 cycles with a stray ack
    for (int i = 0; i < 10; i++) begin
      ifa.wb_ack_i = (i == 3);
      ifa.wb_dat_i = 32'hFFFF_FFFF;
      at_neg();
      chk("bp rsp_valid", 32'(a_rsp_valid), 32'd1);
      chk("bp rsp_dat", a_rsp_dat, 32'h1234_5678);
      chk("bp rsp_err", 32'(a_rsp_err), 32'd0);
      chk("bp req_ready", 32'(a_req_ready), 32'd0);
      tick();
    end
    ifa.wb_ack_i = 1'b0; a_rsp_ready = 1'b1;
    at_neg();
    chk("bp release rsp_valid", 32'(a_rsp_valid), 32'd1);
    tick();
    at_neg();
    chk("bp after req_ready", 32'(a_req_ready), 32'd1);
    chk("bp after rsp_valid", 32'(a_rsp_valid), 32'd0);

    // reset in cycle 2 of a read waiting for ack
    a_req_valid = 1'b1; a_req_adr = 32'h3080_0000; a_req_we = 1'b0;
    tick(); a_req_valid = 1'b0;
    tick(); a_rst = 1'b1;
    at_neg();
    chk("rst pre cyc", 32'(ifa.wb_cyc_o), 32'd1);
    tick(); a_rst = 1'b0;
    at_neg();
    chk("rst cyc", 32'(ifa.wb_cyc_o), 32'd0);
    chk("rst stb", 32'(ifa.wb_stb_o), 32'd0);
    chk("rst rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst req_ready", 32'(a_req_ready), 32'd1);
    chk("rst timeout_count", 32'(a_tc), 32'd0);
    a_req_valid = 1'b1; a_req_adr = 32'h3080_0004;
    tick(); a_req_valid = 1'b0; ifa.wb_ack_i = 1'b1; ifa.wb_dat_i = 32'h5A5A_5A5A;
    tick(); ifa.wb_ack_i = 1'b0;
    at_neg();
    chk("post-rst rd rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("post-rst rd rsp_dat", a_rsp_dat, 32'h5A5A_5A5A);
    chk("post-rst rd rsp_err", 32'(a_rsp_err), 32'd0);
    tick();

    // randomized traffic, checked cycle by cycle by the model
    for (int n = 0; n < 3000; n++) begin
      a_rst        = ($urandom_range(0, 199) == 0);
      a_req_valid  = 1'($urandom_range(0, 1));
      a_req_adr    = $urandom;
      a_req_dat    = $urandom;
      a_req_sel    = 4'($urandom);
      a_req_we     = 1'($urandom);
      ifa.wb_ack_i = ($urandom_range(0, 9) < 3);
      ifa.wb_dat_i = $urandom;
      a_rsp_ready  = ($urandom_range(0, 9) < 6);
      tick();
    end
    a_rst = 1'b0; a_req_valid = 1'b0; ifa.wb_ack_i = 1'b0; a_rsp_ready = 1'b1;
    repeat (8) tick();
  endtask

  // Instance B: requests always offered, never acked, response always taken.
  // Each transfer is IDLE, BUS, RESP -> a 3-cycle period after reset release.
  task automatic run_b();
    b_rst = 1'b1; b_req_valid = 1'b1; b_req_adr = 32'h4000_0000; b_req_dat = '0;
    b_req_sel = 4'hF; b_req_we = 1'b0; b_rsp_ready = 1'b1;
    ifb.wb_ack_i = 1'b0; ifb.wb_dat_i = '0;
    tick(); tick();
    b_rst = 1'b0;
    tick();
    for (int c = 1; c <= 903; c++) begin
      int exp_tc;
      exp_tc = (c + 1) / 3;
      if (exp_tc > 255) exp_tc = 255;
      at_neg();
      chk("b2b cyc", 32'(ifb.wb_cyc_o), 32'(c % 3 == 1));
      chk("b2b rsp_valid", 32'(b_rsp_valid), 32'(c % 3 == 2));
      chk("b2b rsp_err", 32'(b_rsp_err), 32'(c % 3 == 2));
      chk("b2b req_ready", 32'(b_req_ready), 32'(c % 3 == 0));
      chk("b2b timeout_count", 32'(b_tc), 32'(exp_tc));
      tick();
    end
    at_neg();
    chk("b2b saturated", 32'(b_tc), 32'd255);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
